fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline: holds the fetch PC, selects the next PC, and owns the IF/ID pipeline register that supplies the decode-stage instruction, PC and delay-slot flag. It consumes the branch-condition bit computed in decode for the instruction it previously delivered. Exception entry, `eret` return, hazard stalls and fetch address errors are all resolved here before anything reaches decode.

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_stage_npc.sv | 40 ++++
 rtl/fetch_stage.sv | 69 ++++++
 tb/tb_fetch_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: MIPS opcode/funct/rt encodings shared by the fetch stage.
package fetch_stage_pkg;
    localparam logic [5:0]  SPECIAL_OP   = 6'h00;
    localparam logic [5:0]  BLTZ_BGEZ_OP = 6'h01;
    localparam logic [5:0]  J_OP         = 6'h02;
    localparam logic [5:0]  JAL_OP       = 6'h03;
    localparam logic [5:0]  BEQ_OP       = 6'h04;
    localparam logic [5:0]  BNE_OP       = 6'h05;
    localparam logic [5:0]  BLEZ_OP      = 6'h06;
    localparam logic [5:0]  BGTZ_OP      = 6'h07;
    localparam logic [4:0]  BLTZ_RT      = 5'h00;
    localparam logic [4:0]  BGEZ_RT      = 5'h01;
    localparam logic [5:0]  JR_FUNCT     = 6'h08;
    localparam logic [5:0]  JALR_FUNCT   = 6'h09;
    localparam logic [31:0] ERET_WORD    = 32'h4200_0018;
endpackage

// File: rtl/fetch_stage_npc.sv
// npc: next-PC computation for the instruction sitting in decode.
// Ports: ir_d/pc_d (decode instruction and PC), pc_f (fetch PC), zero (branch
// condition), rs_val_d (jr/jalr target) -> next_pc, is_ctrl (ir_d transfers control).
module npc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] ir_d,
    input  logic [31:0] pc_d,
    input  logic [31:0] pc_f,
    input  logic        zero,
    input  logic [31:0] rs_val_d,
    output logic [31:0] next_pc,
    output logic        is_ctrl
);
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic        is_br;
    logic        is_j;
    logic        is_jr;
    logic [31:0] pc_d4;
    logic [31:0] br_tgt;

    assign op     = ir_d[31:26];
    assign rt     = ir_d[20:16];
    assign funct  = ir_d[5:0];
    assign is_br  = op == BEQ_OP || op == BNE_OP || op == BLEZ_OP || op == BGTZ_OP ||
                    (op == BLTZ_BGEZ_OP && (rt == BLTZ_RT || rt == BGEZ_RT));
    assign is_j   = op == J_OP || op == JAL_OP;
    assign is_jr  = op == SPECIAL_OP && (funct == JR_FUNCT || funct == JALR_FUNCT);
    assign pc_d4  = pc_d + 32'd4;
    assign br_tgt = pc_d4 + {{14{ir_d[15]}}, ir_d[15:0], 2'b00};

    // A not-taken branch still falls through from the fetch PC, so the
    // delay slot already being fetched is followed by its successor.
    assign next_pc = is_br ? (zero ? br_tgt : pc_f + 32'd4) :
                     is_j  ? {pc_d4[31:28], ir_d[25:0], 2'b00} :
                     is_jr ? rs_val_d : pc_f + 32'd4;
    assign is_ctrl = is_br || is_j || is_jr;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage holding the fetch PC and the IF/ID register.
// Ports: clk, reset (async active-low); i_inst_addr/i_inst_rdata (instruction
// memory); stall, zero, rs_val_D, req, EPC (control inputs); PC_F (fetch PC);
// IR_D, PC_D, BD_D, exc_adel_D (IF/ID register outputs).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_LO     = 32'h0000_3000,
    parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    input  logic        stall,
    input  logic        zero,
    input  logic [31:0] rs_val_D,
    input  logic        req,
    input  logic [31:0] EPC,
    output logic [31:0] PC_F,
    output logic [31:0] IR_D,
    output logic [31:0] PC_D,
    output logic        BD_D,
    output logic        exc_adel_D
);
    logic [31:0] next_pc;
    logic        is_ctrl;
    logic        is_eret;
    logic        adel;

    npc u_npc (
        .ir_d    (IR_D),
        .pc_d    (PC_D),
        .pc_f    (PC_F),
        .zero    (zero),
        .rs_val_d(rs_val_D),
        .next_pc (next_pc),
        .is_ctrl (is_ctrl)
    );

    assign i_inst_addr = PC_F;
    assign is_eret     = IR_D == ERET_WORD;
    assign adel        = PC_F[1:0] != 2'b00 || PC_F < IM_LO || PC_F > IM_HI;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC_F       <= RESET_PC;
            IR_D       <= '0;
            PC_D       <= RESET_PC;
            BD_D       <= 1'b0;
            exc_adel_D <= 1'b0;
        end else if (req) begin
            PC_F       <= EXC_ENTRY;
            IR_D       <= '0;
            PC_D       <= EXC_ENTRY;
            BD_D       <= 1'b0;
            exc_adel_D <= 1'b0;
        end else if (!stall) begin
            // eret squashes the word being fetched: it returns with no delay slot.
            PC_F       <= is_eret ? EPC : next_pc;
            PC_D       <= PC_F;
            IR_D       <= (is_eret || adel) ? '0 : i_inst_rdata;
            BD_D       <= !is_eret && is_ctrl;
            exc_adel_D <= !is_eret && adel;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic        stall = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] rs_val_D = '0;
    logic        req = 1'b0;
    logic [31:0] EPC = '0;
    logic [31:0] PC_F, IR_D, PC_D;
    logic        BD_D, exc_adel_D;
    logic [31:0] im [0:255];
    int tests = 0;
    int fails = 0;

    localparam logic [31:0] W0 = 32'h2401_0001;
    localparam logic [31:0] W1 = 32'h2402_0002;
    localparam logic [31:0] W2 = 32'h2403_0003;
    localparam logic [31:0] W3 = 32'h2404_0004;

    always #5 clk = ~clk;

    assign i_inst_rdata = im[i_inst_addr[9:2]];

    fetch_stage dut (
        .clk(clk), .reset(reset), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
        .stall(stall), .zero(zero), .rs_val_D(rs_val_D), .req(req), .EPC(EPC),
        .PC_F(PC_F), .IR_D(IR_D), .PC_D(PC_D), .BD_D(BD_D), .exc_adel_D(exc_adel_D)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; zero = 1'b0; req = 1'b0; rs_val_D = '0; EPC = '0;
        for (int i = 0; i < 256; i++) im[i] = W0 + i;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        restart();
        @(negedge clk);
        reset = 1'b0;
        #2;
        tests++; if (PC_F !== 32'h3000) begin fails++; $display("FAIL reset_pc_f got=%h exp=%h", PC_F, 32'h3000); end
        tests++; if (IR_D !== 32'h0) begin fails++; $display("FAIL reset_ir_d got=%h exp=%h", IR_D, 32'h0); end
        tests++; if (PC_D !== 32'h3000) begin fails++; $display("FAIL reset_pc_d got=%h exp=%h", PC_D, 32'h3000); end
        tests++; if ({BD_D, exc_adel_D} !== 2'b00) begin fails++; $display("FAIL reset_flags got=%b exp=00", {BD_D, exc_adel_D}); end
        @(negedge clk);
        reset = 1'b1;
        step();
        tests++; if (PC_F !== 32'h3004 || IR_D !== W0 || PC_D !== 32'h3000) begin fails++; $display("FAIL seq1 got pc_f=%h ir=%h pc_d=%h exp 3004 %h 3000", PC_F, IR_D, PC_D, W0); end
        tests++; if (i_inst_addr !== PC_F) begin fails++; $display("FAIL inst_addr got=%h exp=%h", i_inst_addr, PC_F); end
        step();
        tests++; if (PC_F !== 32'h3008 || IR_D !== W0 + 1 || PC_D !== 32'h3004) begin fails++; $display("FAIL seq2 got pc_f=%h ir=%h pc_d=%h exp 3008 %h 3004", PC_F, IR_D, PC_D, W0 + 1); end
    endtask

    task automatic test_branch();
        restart();
        im[0] = 32'h1000_0003; im[1] = W1; im[4] = W2;
        zero = 1'b1;
        step();
        tests++; if (IR_D !== 32'h1000_0003 || BD_D !== 1'b0) begin fails++; $display("FAIL beq_in_d got ir=%h bd=%b exp 10000003 0", IR_D, BD_D); end
        step();
        tests++; if (PC_F !== 32'h3010 || IR_D !== W1 || PC_D !== 32'h3004 || BD_D !== 1'b1) begin fails++; $display("FAIL beq_slot got pc_f=%h ir=%h pc_d=%h bd=%b exp 3010 %h 3004 1", PC_F, IR_D, PC_D, BD_D, W1); end
        step();
        tests++; if (PC_F !== 32'h3014 || IR_D !== W2 || PC_D !== 32'h3010 || BD_D !== 1'b0) begin fails++; $display("FAIL beq_target got pc_f=%h ir=%h pc_d=%h bd=%b exp 3014 %h 3010 0", PC_F, IR_D, PC_D, BD_D, W2); end
        restart();
        im[0] = 32'h1400_0003;
        zero = 1'b0;
        step();
        step();
        tests++; if (PC_F !== 32'h3008 || BD_D !== 1'b1) begin fails++; $display("FAIL bne_not_taken got pc_f=%h bd=%b exp 3008 1", PC_F, BD_D); end
    endtask

    task automatic test_jump();
        logic [31:0] tgt [2] = '{32'h6FFC, 32'h7000};
        logic [31:0] exp_ir [2] = '{W3, 32'h0};
        logic        exp_adel [2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            restart();
            im[0] = 32'h0800_0000 | (tgt[k] >> 2); im[1] = W1; im[255] = W3;
            step();
            step();
            tests++; if (PC_F !== tgt[k] || BD_D !== 1'b1 || IR_D !== W1) begin fails++; $display("FAIL j_slot%0d got pc_f=%h bd=%b ir=%h exp %h 1 %h", k, PC_F, BD_D, IR_D, tgt[k], W1); end
            step();
            tests++; if (PC_D !== tgt[k] || IR_D !== exp_ir[k] || exc_adel_D !== exp_adel[k] || PC_F !== tgt[k] + 4) begin fails++; $display("FAIL j_bound%0d got pc_d=%h ir=%h adel=%b pc_f=%h exp %h %h %b %h", k, PC_D, IR_D, exc_adel_D, PC_F, tgt[k], exp_ir[k], exp_adel[k], tgt[k] + 4); end
        end
    endtask

    task automatic test_jr_misaligned();
        restart();
        im[2] = 32'h0000_0008; im[3] = W3;
        rs_val_D = 32'h3002;
        repeat (3) step();
        tests++; if (IR_D !== 32'h0000_0008 || PC_D !== 32'h3008) begin fails++; $display("FAIL jr_in_d got ir=%h pc_d=%h exp 00000008 3008", IR_D, PC_D); end
        step();
        tests++; if (PC_F !== 32'h3002 || IR_D !== W3 || BD_D !== 1'b1) begin fails++; $display("FAIL jr_slot got pc_f=%h ir=%h bd=%b exp 3002 %h 1", PC_F, IR_D, BD_D, W3); end
        step();
        tests++; if (IR_D !== 32'h0 || exc_adel_D !== 1'b1 || PC_D !== 32'h3002 || PC_F !== 32'h3006) begin fails++; $display("FAIL jr_adel got ir=%h adel=%b pc_d=%h pc_f=%h exp 0 1 3002 3006", IR_D, exc_adel_D, PC_D, PC_F); end
    endtask

    task automatic test_wrap();
        restart();
        im[0] = 32'h0000_0008;
        rs_val_D = 32'hFFFF_FFFC;
        step();
        step();
        tests++; if (PC_F !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_tgt got=%h exp=fffffffc", PC_F); end
        step();
        tests++; if (PC_F !== 32'h0 || exc_adel_D !== 1'b1 || IR_D !== 32'h0) begin fails++; $display("FAIL wrap_over got pc_f=%h adel=%b ir=%h exp 0 1 0", PC_F, exc_adel_D, IR_D); end
        step();
        tests++; if (PC_F !== 32'h4 || PC_D !== 32'h0 || exc_adel_D !== 1'b1) begin fails++; $display("FAIL wrap_low got pc_f=%h pc_d=%h adel=%b exp 4 0 1", PC_F, PC_D, exc_adel_D); end
    endtask

    task automatic test_eret_stall();
        restart();
        im[0] = 32'h4200_0018; im[1] = W1; im[8] = W2;
        step();
        stall = 1'b1; EPC = 32'h3020;
        for (int k = 0; k < 2; k++) begin
            step();
            tests++; if (PC_F !== 32'h3004 || IR_D !== 32'h4200_0018 || PC_D !== 32'h3000) begin fails++; $display("FAIL eret_hold%0d got pc_f=%h ir=%h pc_d=%h exp 3004 42000018 3000", k, PC_F, IR_D, PC_D); end
        end
        stall = 1'b0;
        step();
        tests++; if (PC_F !== 32'h3020 || IR_D !== 32'h0 || PC_D !== 32'h3004 || BD_D !== 1'b0) begin fails++; $display("FAIL eret_bubble got pc_f=%h ir=%h pc_d=%h bd=%b exp 3020 0 3004 0", PC_F, IR_D, PC_D, BD_D); end
        step();
        tests++; if (IR_D !== W2 || PC_D !== 32'h3020) begin fails++; $display("FAIL eret_target got ir=%h pc_d=%h exp %h 3020", IR_D, PC_D, W2); end
    endtask

    task automatic test_req();
        restart();
        im[0] = 32'h1000_0003; im[96] = W3;
        zero = 1'b1;
        step();
        req = 1'b1; stall = 1'b1;
        step();
        tests++; if (PC_F !== 32'h4180 || IR_D !== 32'h0 || PC_D !== 32'h4180 || BD_D !== 1'b0 || exc_adel_D !== 1'b0) begin fails++; $display("FAIL req_flush got pc_f=%h ir=%h pc_d=%h bd=%b adel=%b exp 4180 0 4180 0 0", PC_F, IR_D, PC_D, BD_D, exc_adel_D); end
        req = 1'b0; stall = 1'b0;
        step();
        tests++; if (PC_F !== 32'h4184 || IR_D !== W3 || PC_D !== 32'h4180) begin fails++; $display("FAIL req_handler got pc_f=%h ir=%h pc_d=%h exp 4184 %h 4180", PC_F, IR_D, PC_D, W3); end
    endtask

    task automatic test_reset_mid();
        restart();
        repeat (16) step();
        tests++; if (PC_F !== 32'h3040 || IR_D !== W0 + 15) begin fails++; $display("FAIL mid_pre got pc_f=%h ir=%h exp 3040 %h", PC_F, IR_D, W0 + 15); end
        #2;
        reset = 1'b0;
        #1;
        tests++; if (PC_F !== 32'h3000 || IR_D !== 32'h0 || PC_D !== 32'h3000 || BD_D !== 1'b0 || exc_adel_D !== 1'b0) begin fails++; $display("FAIL mid_async got pc_f=%h ir=%h pc_d=%h bd=%b adel=%b exp 3000 0 3000 0 0", PC_F, IR_D, PC_D, BD_D, exc_adel_D); end
        @(negedge clk);
        reset = 1'b1;
        step();
        tests++; if (PC_F !== 32'h3004 || IR_D !== W0) begin fails++; $display("FAIL mid_release got pc_f=%h ir=%h exp 3004 %h", PC_F, IR_D, W0); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_jr_misaligned();
        test_wrap();
        test_eret_stall();
        test_req();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
